// File: rtl/snn_input_loader.sv
// Unpacks UART image bytes LSB-first into the 1-bit SNN input-unit RAM and pulses start per image.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CKSUM_EN.
module snn_input_loader #(
  parameter int NUM_BYTES = 98,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  output logic              ram_we,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              img_err
);

  localparam int BC_W = $clog2(NUM_BYTES + 1);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    RX_WAIT   = 3'd0,
    UNPACK    = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RX_CKSUM  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          shreg, shreg_nxt;
  logic [2:0]          bit_cnt, bit_cnt_nxt;
  logic [BC_W-1:0]     byte_cnt, byte_cnt_nxt;
  logic                clr_nxt, we_nxt, d_nxt, start_nxt, busy_nxt;
  logic [ADDR_W-1:0]   addr_nxt;

  // Byte k, bit b lands at 8k+b: the address is just the concatenation.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [BC_W-1:0] b,
                                                  input logic [2:0]      i);
    logic [BC_W+2:0] a;
    a = {b, i};
    return ADDR_W'(a);
  endfunction

`ifdef LOADER_CKSUM_EN
  logic [7:0] xor_acc, xor_nxt;
  logic       err_nxt;
`endif

  // Registered state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_WAIT;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      clr_rx_rdy <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_d      <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
`ifdef LOADER_CKSUM_EN
      xor_acc    <= '0;
      img_err    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      clr_rx_rdy <= clr_nxt;
      ram_we     <= we_nxt;
      ram_addr   <= addr_nxt;
      ram_d      <= d_nxt;
      start      <= start_nxt;
      busy       <= busy_nxt;
`ifdef LOADER_CKSUM_EN
      xor_acc    <= xor_nxt;
      img_err    <= err_nxt;
`endif
    end
  end

`ifndef LOADER_CKSUM_EN
  assign img_err = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    clr_nxt      = 1'b0;
    we_nxt       = 1'b0;
    addr_nxt     = ram_addr;
    d_nxt        = ram_d;
    start_nxt    = 1'b0;
    busy_nxt     = busy;
`ifdef LOADER_CKSUM_EN
    xor_nxt      = xor_acc;
    err_nxt      = 1'b0;
`endif
    case (state)
      RX_WAIT: begin
        if (rx_rdy) begin
          shreg_nxt   = rx_data;
          bit_cnt_nxt = 3'd0;
          clr_nxt     = 1'b1;
          state_nxt   = UNPACK;
          if (byte_cnt == '0) busy_nxt = 1'b1;
`ifdef LOADER_CKSUM_EN
          xor_nxt     = xor_acc ^ rx_data;
`endif
        end
      end
      UNPACK: begin
        we_nxt      = 1'b1;
        addr_nxt    = pix_addr(byte_cnt, bit_cnt);
        d_nxt       = shreg[0];
        shreg_nxt   = {1'b0, shreg[7:1]};
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_nxt = '0;
`ifdef LOADER_CKSUM_EN
            state_nxt    = RX_CKSUM;
`else
            state_nxt    = START;
`endif
          end else begin
            byte_cnt_nxt = byte_cnt + BC_W'(1);
            state_nxt    = RX_WAIT;
          end
        end
      end
      START: begin
        start_nxt = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A byte held by the UART here stays pending until the core is done.
        if (done) begin
          busy_nxt  = 1'b0;
          state_nxt = RX_WAIT;
        end
      end
      RX_CKSUM: begin
`ifdef LOADER_CKSUM_EN
        if (rx_rdy) begin
          clr_nxt = 1'b1;
          xor_nxt = '0;
          if (rx_data == xor_acc) begin
            state_nxt = START;
          end else begin
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = RX_WAIT;
          end
        end
`else
        state_nxt = RX_WAIT;
`endif
      end
      default: state_nxt = RX_WAIT;
    endcase
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed bench for snn_input_loader: a byte table plus hand-written image, hold-off and reset sequences.
module tb_snn_input_loader;

  localparam int NUM_BYTES = 98;
  localparam int ADDR_W    = 10;
  localparam int NPIX      = 8 * NUM_BYTES;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_d;
  logic              ram_we;
  logic              start;
  logic              done;
  logic              busy;
  logic              img_err;

  snn_input_loader #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .start(start), .done(done),
    .busy(busy), .img_err(img_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   wr_addr[$];
  logic wr_d[$];
  int   clr_cnt = 0, start_cnt = 0, err_cnt = 0;
  int   start_cyc = 0, last_wr_cyc = 0, last_clr_cyc = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr.push_back(int'(ram_addr));
      wr_d.push_back(ram_d);
      last_wr_cyc = cyc;
    end
    if (clr_rx_rdy) begin clr_cnt++; last_clr_cyc = cyc; end
    if (start) begin start_cnt++; start_cyc = cyc; end
    if (img_err) err_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_log();
    wr_addr.delete();
    wr_d.delete();
    clr_cnt = 0; start_cnt = 0; err_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (clr_rx_rdy) begin ok = 1'b1; break; end
    end
    rx_rdy = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL clr_timeout: got 0 expected 1");
    end
  endtask

  task automatic send_image(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) send_byte(b);
  endtask

  task automatic wait_start();
    for (int n = 0; n < 40; n++) begin
      if (start_cnt > 0) break;
      tick();
    end
    tick();
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Compare the 8 writes logged from index idx against a base address and an address-order bit pattern.
  task automatic check_byte(input string name, input int idx, input int exp_base, input logic [0:7] exp_seq);
    int         bad;
    logic [0:7] got_seq;
    bad = 0;
    got_seq = '0;
    check({name, "_nwr"}, (wr_addr.size() >= idx + 8), 1);
    if (wr_addr.size() >= idx + 8) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_addr[idx + b] != exp_base + b) bad++;
        got_seq[b] = wr_d[idx + b];
      end
      check({name, "_addr_bad"}, bad, 0);
      check({name, "_bits"}, got_seq, exp_seq);
    end
  endtask

  task automatic check_full_ones(input string name);
    int bad;
    bad = 0;
    check({name, "_nwr"}, wr_addr.size(), NPIX);
    if (wr_addr.size() == NPIX)
      for (int i = 0; i < NPIX; i++)
        if (wr_addr[i] != i || wr_d[i] !== 1'b1) bad++;
    check({name, "_order_bad"}, bad, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [0:7] seq;
    int         base;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'b10100101, 0};
    vecs[1] = '{8'h01, 8'b10000000, 8};
    vecs[2] = '{8'h80, 8'b00000001, 16};
    vecs[3] = '{8'h3C, 8'b00111100, 24};
    vecs[4] = '{8'hF0, 8'b00001111, 32};
    vecs[5] = '{8'h96, 8'b01101001, 40};

    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; done = 1'b0;
    tick();
    tick();
    check("rst_clr", clr_rx_rdy, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_d", ram_d, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", img_err, 0);
    rst = 1'b0;
    tick();

    // Full image of 0xFF
    clr_log();
    send_image(8'hFF, NUM_BYTES);
    wait_start();
    check_full_ones("t1");
    check("t1_clr_cnt", clr_cnt, NUM_BYTES);
    check("t1_start_cnt", start_cnt, 1);
    check("t1_start_lat", start_cyc - last_wr_cyc, 1);
    check("t1_busy_hold", busy, 1);
    pulse_done();
    check("t1_busy_clr", busy, 0);

    // Table of individual bytes forming the head of an image
    do_reset();
    clr_log();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_busy_before%0d", i), busy, (i != 0));
      send_byte(vecs[i].data);
      check($sformatf("t2_busy_accept%0d", i), busy, 1);
      repeat (9) tick();
      check_byte($sformatf("t2_v%0d", i), 8 * i, vecs[i].base, vecs[i].seq);
    end

    // Stray done mid-image is ignored
    pulse_done();
    tick();
    check("t5_busy", busy, 1);
    send_byte(8'h01);
    repeat (9) tick();
    check_byte("t5_next", 48, 48, 8'b10000000);
    check("t5_start_cnt", start_cnt, 0);

    // Byte held during WAIT_DONE is taken only after done
    do_reset();
    clr_log();
    send_image(8'h00, NUM_BYTES);
    wait_start();
    rx_data = 8'h3C;
    rx_rdy  = 1'b1;
    repeat (20) tick();
    check("t3_clr_held", clr_cnt, NUM_BYTES);
    check("t3_nwr_held", wr_addr.size(), NPIX);
    check("t3_busy_held", busy, 1);
    pulse_done();
    for (int n = 0; n < 20; n++) begin
      if (clr_rx_rdy) break;
      tick();
    end
    rx_rdy = 1'b0;
    check("t3_clr_after", clr_cnt, NUM_BYTES + 1);
    repeat (9) tick();
    check_byte("t3_3c", NPIX, 0, 8'b00111100);

    // Reset in the middle of an image discards it
    do_reset();
    clr_log();
    send_image(8'h00, 50);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t4_busy_rst", busy, 0);
    clr_log();
    send_image(8'hFF, NUM_BYTES - 1);
    repeat (15) tick();
    check("t4_no_early_start", start_cnt, 0);
    send_byte(8'hFF);
    wait_start();
    check_full_ones("t4");
    check("t4_start_cnt", start_cnt, 1);
    check("t4_start_after_last", start_cyc > last_clr_cyc, 1);
    pulse_done();

`ifdef LOADER_CKSUM_EN
    // Checksum match then mismatch
    do_reset();
    clr_log();
    send_image(8'h01, NUM_BYTES);
    send_byte(8'h00);
    wait_start();
    check("t6_ok_start", start_cnt, 1);
    check("t6_ok_err", err_cnt, 0);
    pulse_done();
    clr_log();
    send_image(8'h01, NUM_BYTES);
    send_byte(8'h01);
    repeat (15) tick();
    check("t6_bad_start", start_cnt, 0);
    check("t6_bad_err", err_cnt, 1);
    check("t6_bad_busy", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
